simple: RTL and testbench



---
 rtl/simple_pkg.sv | 13 +
 rtl/simple_tap_line.sv | 30 +++
 rtl/simple.sv | 53 +++++
 tb/tb_simple.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/simple_pkg.sv
// Shared constants and helpers for the simple moving-average filter.
// The optional SIMPLE_ROUND_EN macro is consumed by rtl/simple.sv.
package simple_pkg;

    localparam int SIMPLE_WIDTH     = 8;
    localparam int SIMPLE_TAPS_LOG2 = 2;

    // Running sum must hold N full-scale samples without overflow.
    function automatic int acc_width(input int width, input int taps_log2);
        return width + taps_log2;
    endfunction

endpackage

// File: rtl/simple_tap_line.sv
// Shift register of the most recent DEPTH samples; exposes the oldest one,
// which is the sample leaving the averaging window on the next edge.
module simple_tap_line #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] oldest
);

    logic [WIDTH-1:0] taps [DEPTH];

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                taps[i] <= '0;
            end
        end else begin
            taps[0] <= data_in;
            for (int i = 1; i < DEPTH; i++) begin
                taps[i] <= taps[i-1];
            end
        end
    end

    assign oldest = taps[DEPTH-1];

endmodule

// File: rtl/simple.sv
// Streaming unsigned moving average over the last 2^TAPS_LOG2 samples.
// Define SIMPLE_ROUND_EN to round half up instead of truncating.
module simple
    import simple_pkg::*;
#(
    parameter int WIDTH     = SIMPLE_WIDTH,
    parameter int TAPS_LOG2 = SIMPLE_TAPS_LOG2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out
);

    localparam int DEPTH = 1 << TAPS_LOG2;
    localparam int AW    = acc_width(WIDTH, TAPS_LOG2);

    logic [WIDTH-1:0] oldest;
    logic [AW-1:0]    acc;
    logic [AW-1:0]    acc_next;
    logic [AW-1:0]    rounded;

    simple_tap_line #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_tap_line (
        .clock   (clock),
        .reset   (reset),
        .data_in (data_in),
        .oldest  (oldest)
    );

    // acc always equals the sum of the taps, so this subtraction never underflows.
    assign acc_next = acc + AW'(data_in) - AW'(oldest);

`ifdef SIMPLE_ROUND_EN
    localparam logic [AW-1:0] HALF = AW'(DEPTH / 2);
    assign rounded = acc_next + HALF;
`else
    assign rounded = acc_next;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            acc      <= '0;
            data_out <= '0;
        end else begin
            acc      <= acc_next;
            data_out <= WIDTH'(rounded >> TAPS_LOG2);
        end
    end

endmodule

// File: tb/tb_simple.sv
// Scoreboard bench for the simple moving-average filter (WIDTH=8, N=4).
// Expected outputs are hand-computed for both truncating and rounding builds.
module tb_simple;

    typedef struct {
        logic [7:0] out;
        logic       chk_acc;
        string      name;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] data_in = 8'd0;
    logic [7:0] data_out;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    simple #(
        .WIDTH     (8),
        .TAPS_LOG2 (2)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .data_in  (data_in),
        .data_out (data_out)
    );

    always #5 clock = ~clock;

    // Drive one sample away from the active edge and record what the next edge should produce.
    task automatic applyStimulus(input logic [7:0] d, input logic r,
                                 input logic [7:0] exp_trunc, input logic [7:0] exp_round,
                                 input string name);
        exp_t e;
        @(negedge clock);
        data_in = d;
        reset   = r;
`ifdef SIMPLE_ROUND_EN
        e.out = exp_round;
`else
        e.out = exp_trunc;
`endif
        e.chk_acc = r;
        e.name    = name;
        exp_q.push_back(e);
    endtask

    task automatic checkOutput(input exp_t e);
        checks++;
        if (data_out !== e.out) begin
            errors++;
            $display("[TB] FAIL %s: data_out=%0d expected=%0d", e.name, data_out, e.out);
        end
        if (e.chk_acc) begin
            checks++;
            if (dut.acc !== 10'd0) begin
                errors++;
                $display("[TB] FAIL %s_acc: acc=%0d expected=0", e.name, dut.acc);
            end
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput(e);
            end
        end
    end

    initial begin : stimulus
        int wait_cycles;

        applyStimulus(8'd77, 1'b1, 8'd0, 8'd0, "reset0");
        applyStimulus(8'd77, 1'b1, 8'd0, 8'd0, "reset1");

        applyStimulus(8'd32, 1'b0, 8'd8,  8'd8,  "warm1");
        applyStimulus(8'd32, 1'b0, 8'd16, 8'd16, "warm2");
        applyStimulus(8'd32, 1'b0, 8'd24, 8'd24, "warm3");
        applyStimulus(8'd32, 1'b0, 8'd32, 8'd32, "warm4");
        applyStimulus(8'd32, 1'b0, 8'd32, 8'd32, "steady");

        applyStimulus(8'd28, 1'b0, 8'd31, 8'd31, "step1");
        applyStimulus(8'd28, 1'b0, 8'd30, 8'd30, "step2");
        applyStimulus(8'd28, 1'b0, 8'd29, 8'd29, "step3");
        applyStimulus(8'd28, 1'b0, 8'd28, 8'd28, "step4");

        applyStimulus(8'd28,  1'b0, 8'd28, 8'd28, "mix1");
        applyStimulus(8'd28,  1'b0, 8'd28, 8'd28, "mix2");
        applyStimulus(8'd109, 1'b0, 8'd48, 8'd48, "mix3");
        applyStimulus(8'd111, 1'b0, 8'd69, 8'd69, "mix4");

        applyStimulus(8'hF1, 1'b0, 8'd122, 8'd122, "f1_1");
        applyStimulus(8'hF1, 1'b0, 8'd175, 8'd176, "f1_2");
        applyStimulus(8'hF1, 1'b0, 8'd208, 8'd209, "f1_3");
        applyStimulus(8'hF1, 1'b0, 8'd241, 8'd241, "f1_4");

        applyStimulus(8'hDD, 1'b0, 8'd236, 8'd236, "dd_1");
        applyStimulus(8'hDD, 1'b0, 8'd231, 8'd231, "dd_2");
        applyStimulus(8'hDD, 1'b0, 8'd226, 8'd226, "dd_3");
        applyStimulus(8'hDD, 1'b0, 8'd221, 8'd221, "dd_4");

        applyStimulus(8'd255, 1'b0, 8'd229, 8'd230, "ff_1");
        applyStimulus(8'd255, 1'b0, 8'd238, 8'd238, "ff_2");
        applyStimulus(8'd255, 1'b0, 8'd246, 8'd247, "ff_3");
        applyStimulus(8'd255, 1'b0, 8'd255, 8'd255, "ff_4");

        applyStimulus(8'd0, 1'b0, 8'd191, 8'd191, "drain1");
        applyStimulus(8'd0, 1'b0, 8'd127, 8'd128, "drain2");
        applyStimulus(8'd0, 1'b0, 8'd63,  8'd64,  "drain3");
        applyStimulus(8'd0, 1'b0, 8'd0,   8'd0,   "drain4");

        applyStimulus(8'd255, 1'b0, 8'd63,  8'd64,  "refill1");
        applyStimulus(8'd255, 1'b0, 8'd127, 8'd128, "refill2");
        applyStimulus(8'd255, 1'b0, 8'd191, 8'd191, "refill3");
        applyStimulus(8'd255, 1'b0, 8'd255, 8'd255, "refill4");
        applyStimulus(8'd255, 1'b1, 8'd0,   8'd0,   "mid_reset");
        applyStimulus(8'd32,  1'b0, 8'd8,   8'd8,   "post_reset1");
        applyStimulus(8'd32,  1'b0, 8'd16,  8'd16,  "post_reset2");

        applyStimulus(8'd0, 1'b1, 8'd0, 8'd0, "rnd_reset1");
        applyStimulus(8'd1, 1'b0, 8'd0, 8'd0, "rnd1_a");
        applyStimulus(8'd0, 1'b0, 8'd0, 8'd0, "rnd1_b");
        applyStimulus(8'd0, 1'b0, 8'd0, 8'd0, "rnd1_c");
        applyStimulus(8'd0, 1'b0, 8'd0, 8'd0, "rnd1_d");
        applyStimulus(8'd0, 1'b1, 8'd0, 8'd0, "rnd_reset2");
        applyStimulus(8'd2, 1'b0, 8'd0, 8'd1, "rnd2_a");
        applyStimulus(8'd0, 1'b0, 8'd0, 8'd1, "rnd2_b");
        applyStimulus(8'd0, 1'b0, 8'd0, 8'd1, "rnd2_c");
        applyStimulus(8'd0, 1'b0, 8'd0, 8'd1, "rnd2_d");
        applyStimulus(8'd0, 1'b0, 8'd0, 8'd0, "rnd2_e");

        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 20) begin
            @(negedge clock);
            wait_cycles++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain_queue: pending=%0d expected=0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
